// File: rtl/puf_drv_pkg.sv
// -----------------------------------------------------------------------------
// puf_drv_pkg
// Shared definitions for the PUF challenge driver:
//   - state_t        : driver FSM states
//   - LFSR_TAP       : Galois tap mask for x^128 + x^29 + x^27 + x^2 + 1
//   - DEF_A_OPERAND  : default constant operand a
//   - DEF_B_OPERAND  : default constant operand b
//   - galois_step()  : one right-shifting Galois LFSR step
// -----------------------------------------------------------------------------
package puf_drv_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        FIRE   = 3'd2,
        SAMPLE = 3'd3,
        OUT    = 3'd4,
        NEXT   = 3'd5
    } state_t;

    // Right-shifting Galois form: a term x^k of the polynomial maps to tap
    // bit k-1; the x^0 term is the bit shifted out of position 0.
    localparam logic [127:0] LFSR_TAP = (128'h1 << 127) | (128'h1 << 28) |
                                        (128'h1 << 26)  | (128'h1 << 1);

    localparam logic [15:0] DEF_A_OPERAND = 16'hFFFF;
    localparam logic [15:0] DEF_B_OPERAND = 16'h0001;

    function automatic logic [127:0] galois_step(input logic [127:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAP) : (s >> 1);
    endfunction

endpackage

// File: rtl/puf_lfsr128.sv
// -----------------------------------------------------------------------------
// puf_lfsr128
// 128-bit Galois LFSR that generates the challenge sequence.
// Ports:
//   clk, reset : clock, asynchronous active-high reset (state clears to 0)
//   load       : load seed (an all-zero seed is replaced by 128'h1 so the
//                register never locks up)
//   step       : advance one Galois step (ignored while load is high)
//   seed       : seed value
//   state      : current LFSR contents
// -----------------------------------------------------------------------------
module puf_lfsr128
    import puf_drv_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         step,
    input  logic [127:0] seed,
    output logic [127:0] state
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= '0;
        end else if (load) begin
            state <= (seed == '0) ? 128'h1 : seed;
        end else if (step) begin
            state <= galois_step(state);
        end
    end

endmodule

// File: rtl/puf_challenge_driver.sv
// -----------------------------------------------------------------------------
// puf_challenge_driver
// Drives a sequence of LFSR-generated challenges into a PUF array, fires the
// array, captures each response and hands it out over a valid/ready port.
//
// Parameters: SETTLE_CYCLES (>=2), TRIG_CYCLES (>=1), A_OPERAND, B_OPERAND.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   start, num_chal, seed : run request (sampled in IDLE only) and its setup
//   challenge             : applied challenge, [63:0] top path, [127:64] bottom
//   trigger, puf_reset    : fire strobe and arbiter clear to the array
//   a_op, b_op            : constant operands
//   response              : PUF response bits
//   rsp_valid/rsp_ready   : output handshake; rsp_data/rsp_index payload
//   busy, done            : run in progress; one-cycle end-of-run pulse
//   dbg_state             : current FSM state for observation
//
// Handshake: a beat transfers on the rising edge where rsp_valid && rsp_ready;
// rsp_valid, rsp_data and rsp_index stay constant from the rise of rsp_valid
// until that edge, and rsp_valid drops right after it.
//
// Optional feature: define PUF_MAJORITY_VOTE_EN to fire each challenge three
// times and report the bitwise 2-of-3 majority of the three responses.
//
// All array-facing and handshake outputs are registered from the current
// state, so they appear one cycle after the state is entered. That lag gives
// the trigger rise SETTLE_CYCLES+1 cycles after start acceptance and rsp_valid
// TRIG_CYCLES+1 cycles after the trigger rise. The response is sampled on the
// edge that drops trigger.
// -----------------------------------------------------------------------------
module puf_challenge_driver
    import puf_drv_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned TRIG_CYCLES   = 4,
    parameter logic [15:0] A_OPERAND     = DEF_A_OPERAND,
    parameter logic [15:0] B_OPERAND     = DEF_B_OPERAND
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [15:0]  num_chal,
    input  logic [127:0] seed,
    output logic [127:0] challenge,
    output logic         trigger,
    output logic [15:0]  a_op,
    output logic [15:0]  b_op,
    output logic         puf_reset,
    input  logic [15:0]  response,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [15:0]  rsp_data,
    output logic [15:0]  rsp_index,
    output logic         busy,
    output logic         done,
    output state_t       dbg_state
);

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] TRIG_LAST   = 16'(TRIG_CYCLES - 1);

    state_t        state;
    state_t        next_state;
    logic [15:0]   cnt;
    logic [15:0]   index;
    logic [15:0]   num_chal_r;
    logic [127:0]  lfsr_state;
    logic          accept;
    logic          last;
    logic          handshake;
    logic          final_pass;

    assign a_op      = A_OPERAND;
    assign b_op      = B_OPERAND;
    assign dbg_state = state;

    assign accept    = (state == IDLE) && start;
    assign last      = (index == (num_chal_r - 16'd1));
    assign handshake = rsp_valid && rsp_ready;

`ifdef PUF_MAJORITY_VOTE_EN
    logic [1:0]  pass;
    logic [15:0] vote0;
    logic [15:0] vote1;

    assign final_pass = (pass == 2'd2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pass  <= 2'd0;
            vote0 <= '0;
            vote1 <= '0;
        end else if (accept) begin
            pass <= 2'd0;
        end else if (state == SAMPLE) begin
            case (pass)
                2'd0:    vote0 <= response;
                2'd1:    vote1 <= response;
                default: ;
            endcase
            pass <= final_pass ? 2'd0 : pass + 2'd1;
        end
    end
`else
    assign final_pass = 1'b1;
`endif

    puf_lfsr128 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .step  ((state == NEXT) && !last),
        .seed  (seed),
        .state (lfsr_state)
    );

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start && (num_chal != 16'd0)) next_state = ARM;
            ARM:     if (cnt == SETTLE_LAST) next_state = FIRE;
            FIRE:    if (cnt == TRIG_LAST) next_state = SAMPLE;
            SAMPLE:  next_state = final_pass ? OUT : ARM;
            OUT:     if (handshake) next_state = NEXT;
            NEXT:    next_state = last ? IDLE : ARM;
            default: next_state = IDLE;
        endcase
    end

    // State register and phase counter (counts cycles spent in ARM / FIRE)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (((state == ARM) || (state == FIRE)) && (next_state == state)) begin
                cnt <= cnt + 16'd1;
            end else begin
                cnt <= '0;
            end
        end
    end

    // Run bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            index      <= '0;
            num_chal_r <= '0;
        end else if (accept) begin
            index      <= '0;
            num_chal_r <= num_chal;
        end else if ((state == NEXT) && !last) begin
            index <= index + 16'd1;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            challenge <= '0;
            trigger   <= 1'b0;
            puf_reset <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_index <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            trigger   <= (state == FIRE);
            puf_reset <= (state == ARM) && (cnt == 16'd0);
            rsp_valid <= (state == OUT) && !handshake;
            busy      <= (state != IDLE);
            done      <= (accept && (num_chal == 16'd0)) || ((state == NEXT) && last);
            if (state == ARM) begin
                challenge <= lfsr_state;
            end
            if ((state == SAMPLE) && final_pass) begin
`ifdef PUF_MAJORITY_VOTE_EN
                rsp_data <= (vote0 & vote1) | (vote0 & response) | (vote1 & response);
`else
                rsp_data <= response;
`endif
                rsp_index <= index;
            end
        end
    end

endmodule

// File: tb/tb_puf_challenge_driver.sv
// -----------------------------------------------------------------------------
// tb_puf_challenge_driver
// Self-checking bench for puf_challenge_driver (default parameters). Define
// PUF_MAJORITY_VOTE_EN for both bench and RTL to exercise the voting build.
// -----------------------------------------------------------------------------
module tb_puf_challenge_driver;
    import puf_drv_pkg::*;

    localparam int S = 8;
    localparam int T = 4;
`ifdef PUF_MAJORITY_VOTE_EN
    localparam int PASSES = 3;
`else
    localparam int PASSES = 1;
`endif

    logic         clk;
    logic         reset;
    logic         start;
    logic [15:0]  num_chal;
    logic [127:0] seed;
    logic [127:0] challenge;
    logic         trigger;
    logic [15:0]  a_op;
    logic [15:0]  b_op;
    logic         puf_reset;
    logic [15:0]  response;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [15:0]  rsp_data;
    logic [15:0]  rsp_index;
    logic         busy;
    logic         done;
    state_t       dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [127:0] exp_q[$];

    puf_challenge_driver dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_chal  (num_chal),
        .seed      (seed),
        .challenge (challenge),
        .trigger   (trigger),
        .a_op      (a_op),
        .b_op      (b_op),
        .puf_reset (puf_reset),
        .response  (response),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_index (rsp_index),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // One Galois step of x^128 + x^29 + x^27 + x^2 + 1, right-shifting form.
    function automatic logic [127:0] galois(input logic [127:0] s);
        int exps [4] = '{128, 29, 27, 2};
        logic [127:0] poly;
        poly = '0;
        foreach (exps[j]) poly[exps[j] - 1] = 1'b1;
        return s[0] ? ((s >> 1) ^ poly) : (s >> 1);
    endfunction

    // Bitwise majority by counting ones per bit position.
    function automatic logic [15:0] maj3(input logic [15:0] x, input logic [15:0] y,
                                         input logic [15:0] z);
        logic [15:0] r;
        for (int b = 0; b < 16; b++) begin
            int ones;
            ones = int'(x[b]) + int'(y[b]) + int'(z[b]);
            r[b] = (ones >= 2);
        end
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [15:0] pick_rsp(input int rmode, input int p);
        logic [15:0] tbl [3] = '{16'h00FF, 16'h0F0F, 16'h0033};
        case (rmode)
            1:       return 16'hA5A5;
            2:       return tbl[p];
            default: return 16'($urandom);
        endcase
    endfunction

    // ---------------- driver: one complete run, checked in lockstep ----------------
    // Called on a falling edge with the DUT idle. rmode: 0 random responses,
    // 1 constant 16'hA5A5, 2 fixed vote table per pass.
    task automatic run(input logic [127:0] sd, input logic [15:0] n, input bit stall,
                       input int rmode);
        logic [15:0]  resp [3];
        logic [15:0]  exp_data;
        logic [127:0] c;
        int           nn;
        nn = int'(n);
        resp = '{16'h0, 16'h0, 16'h0};
        rsp_ready = !stall;
        start     = 1'b1;
        num_chal  = n;
        seed      = sd;
        @(negedge clk);                      // accept edge has passed
        start    = 1'b0;
        seed     = rnd128();                 // captured values must be used
        num_chal = 16'($urandom);
        if (nn == 0) begin
            check("zero_done", 128'(done), 128'(1));
            check("zero_busy", 128'(busy), 128'(0));
            @(negedge clk);
            check("zero_done_end", 128'(done), 128'(0));
            check("zero_busy_end", 128'(busy), 128'(0));
            return;
        end
        exp_q.delete();
        c = (sd == '0) ? 128'h1 : sd;
        for (int i = 0; i < nn; i++) begin
            exp_q.push_back(c);
            c = galois(c);
        end
        for (int i = 0; i < nn; i++) begin
            c = exp_q.pop_front();
            for (int p = 0; p < PASSES; p++) begin
                for (int k = 1; k <= S; k++) begin
                    @(negedge clk);
                    check("arm_trigger", 128'(trigger), 128'(0));
                    check("arm_challenge", challenge, c);
                    check("arm_puf_reset", 128'(puf_reset), 128'(k == 1));
                    check("arm_busy", 128'(busy), 128'(1));
                    check("arm_done", 128'(done), 128'(0));
                    if (i == 0 && p == 0 && k == 2) begin
                        start    = 1'b1;     // must be ignored while busy
                        num_chal = 16'($urandom);
                        seed     = rnd128();
                    end
                    if (k == 3) start = 1'b0;
                end
                for (int k = 1; k <= T; k++) begin
                    @(negedge clk);
                    check("fire_trigger", 128'(trigger), 128'(1));
                    check("fire_challenge", challenge, c);
                    check("fire_valid", 128'(rsp_valid), 128'(0));
                    if (k == 1) begin
                        resp[p]  = pick_rsp(rmode, p);
                        response = resp[p];
                    end
                end
                @(negedge clk);
                check("sample_trigger", 128'(trigger), 128'(0));
                check("sample_valid", 128'(rsp_valid), 128'(0));
            end
`ifdef PUF_MAJORITY_VOTE_EN
            exp_data = maj3(resp[0], resp[1], resp[2]);
`else
            exp_data = resp[0];
`endif
            response = 16'($urandom);        // sampled value must already be latched
            @(negedge clk);
            check("out_valid", 128'(rsp_valid), 128'(1));
            check("out_data", 128'(rsp_data), 128'(exp_data));
            check("out_index", 128'(rsp_index), 128'(i));
            check("out_trigger", 128'(trigger), 128'(0));
            if (stall) begin
                repeat (20) begin
                    @(negedge clk);
                    check("hold_valid", 128'(rsp_valid), 128'(1));
                    check("hold_data", 128'(rsp_data), 128'(exp_data));
                    check("hold_index", 128'(rsp_index), 128'(i));
                    check("hold_trigger", 128'(trigger), 128'(0));
                    check("hold_puf_reset", 128'(puf_reset), 128'(0));
                end
                rsp_ready = 1'b1;
            end
            @(negedge clk);                  // handshake edge has passed
            check("hs_valid_drop", 128'(rsp_valid), 128'(0));
            check("hs_done", 128'(done), 128'(0));
            if (stall) rsp_ready = 1'b0;
            @(negedge clk);
            check("next_done", 128'(done), 128'(i == nn - 1));
            if (i == nn - 1) begin
                @(negedge clk);
                check("end_done", 128'(done), 128'(0));
                check("end_busy", 128'(busy), 128'(0));
                check("end_state", 128'(dbg_state), 128'(IDLE));
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        num_chal  = '0;
        seed      = '0;
        response  = '0;
        rsp_ready = 1'b0;

        @(negedge clk);
        @(negedge clk);
        check("rst_challenge", challenge, 128'(0));
        check("rst_trigger", 128'(trigger), 128'(0));
        check("rst_puf_reset", 128'(puf_reset), 128'(1));
        check("rst_valid", 128'(rsp_valid), 128'(0));
        check("rst_data", 128'(rsp_data), 128'(0));
        check("rst_index", 128'(rsp_index), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_state", 128'(dbg_state), 128'(IDLE));
        check("a_op", 128'(a_op), 128'(16'hFFFF));
        check("b_op", 128'(b_op), 128'(16'h0001));
        reset = 1'b0;
        @(negedge clk);
        check("puf_reset_release", 128'(puf_reset), 128'(0));
        check("idle_busy", 128'(busy), 128'(0));

        // Basic run with constant response (or the vote table when voting)
`ifdef PUF_MAJORITY_VOTE_EN
        run(128'h1, 16'd3, 1'b0, 2);
`else
        run(128'h1, 16'd3, 1'b0, 1);
`endif
        // Zero seed substitution plus output back-pressure
        run(128'h0, 16'd2, 1'b1, 0);
        // Empty run
        run(rnd128(), 16'd0, 1'b0, 0);

        // Reset in the middle of FIRE
        rsp_ready = 1'b1;
        start     = 1'b1;
        num_chal  = 16'd3;
        seed      = rnd128();
        @(negedge clk);
        start = 1'b0;
        repeat (S + 2) @(negedge clk);
        check("pre_rst_trigger", 128'(trigger), 128'(1));
        #2 reset = 1'b1;
        #1;
        check("async_trigger", 128'(trigger), 128'(0));
        check("async_valid", 128'(rsp_valid), 128'(0));
        check("async_busy", 128'(busy), 128'(0));
        check("async_puf_reset", 128'(puf_reset), 128'(1));
        check("async_challenge", challenge, 128'(0));
        check("async_state", 128'(dbg_state), 128'(IDLE));
        @(negedge clk);
        reset = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("post_rst_done", 128'(done), 128'(0));
            check("post_rst_busy", 128'(busy), 128'(0));
        end

        // Randomized runs
        for (int r = 0; r < 6; r++) begin
            run(($urandom_range(0, 4) == 0) ? 128'h0 : rnd128(),
                16'($urandom_range(1, 4)), 1'($urandom_range(0, 1)), 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
